// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and widths for the SRAM port arbiter
package sram_arb_pkg;
    localparam int DATA_W = 32;
    localparam int WEN_W = 4;
    typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_e;
endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: saturating count of data grants made while a fetch waits
module arb_starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);
    localparam int CW = LIMIT > 0 ? $clog2(LIMIT + 1) : 1;
    logic [CW-1:0] cnt;
    assign at_limit = cnt == CW'(LIMIT);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && !at_limit) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one synchronous SRAM port between fetch and data requesters
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_gnt,
    output logic              inst_rvalid,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic [WEN_W-1:0]  data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [DATA_W-1:0] data_rdata,
    output logic              sram_en,
    output logic [WEN_W-1:0]  sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);
    owner_e owner;
    logic owner_wr, at_limit, inst_v, data_v;
    // Requests are masked during reset so grants and the SRAM port drop immediately.
    assign inst_v = inst_req && resetn;
    assign data_v = data_req && resetn;
    always_comb begin
        data_gnt = data_v && !(inst_v && at_limit);
        inst_gnt = inst_v && !data_gnt;
        sram_en = inst_gnt || data_gnt;
        sram_addr = data_gnt ? data_addr : inst_gnt ? inst_addr : '0;
        sram_wen = data_gnt ? data_wen : '0;
        sram_wdata = data_gnt ? data_wdata : '0;
    end
    arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk(clk),
        .resetn(resetn),
        .inc(data_gnt && inst_req),
        .clr(inst_gnt || !inst_req),
        .at_limit(at_limit)
    );
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner <= OWN_NONE;
            owner_wr <= 1'b0;
        end else begin
            owner <= data_gnt ? OWN_DATA : inst_gnt ? OWN_INST : OWN_NONE;
            owner_wr <= data_gnt && data_wen != '0;
        end
    end
    always_comb begin
        inst_rvalid = owner == OWN_INST;
        data_rvalid = owner == OWN_DATA;
        inst_rdata = inst_rvalid ? sram_rdata : '0;
        data_rdata = data_rvalid && !owner_wr ? sram_rdata : '0;
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: table-driven and sequence checks of the SRAM port arbiter
module tb_sram_port_arbiter;
    logic clk = 1'b0, resetn = 1'b0;
    logic inst_req = 1'b0, data_req = 1'b0;
    logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0, sram_rdata = '0;
    logic [3:0] data_wen = '0;
    logic inst_gnt, inst_rvalid, data_gnt, data_rvalid, sram_en;
    logic [31:0] inst_rdata, data_rdata, sram_addr, sram_wdata;
    logic [3:0] sram_wen;
    int checks = 0, errors = 0;

    sram_port_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
        .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
        .data_rdata(data_rdata), .sram_en(sram_en), .sram_wen(sram_wen),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ireq; logic [31:0] iaddr;
        logic dreq; logic [3:0] dwen; logic [31:0] daddr, dwdata, srd;
        logic eig, edg; logic [3:0] ewen; logic [31:0] eaddr, ewdata;
        logic eirv, edrv; logic [31:0] eird, edrd;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(logic ireq, logic [31:0] iaddr, logic dreq, logic [3:0] dwen,
                                logic [31:0] daddr, logic [31:0] dwdata, logic [31:0] srd,
                                logic eig, logic edg, logic [3:0] ewen, logic [31:0] eaddr,
                                logic [31:0] ewdata, logic eirv, logic edrv,
                                logic [31:0] eird, logic [31:0] edrd);
        vec_t v;
        v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwen = dwen; v.daddr = daddr;
        v.dwdata = dwdata; v.srd = srd; v.eig = eig; v.edg = edg; v.ewen = ewen;
        v.eaddr = eaddr; v.ewdata = ewdata; v.eirv = eirv; v.edrv = edrv;
        v.eird = eird; v.edrd = edrd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle_port(input string tag);
        chk({tag, " inst_gnt"}, 32'(inst_gnt), 0);
        chk({tag, " data_gnt"}, 32'(data_gnt), 0);
        chk({tag, " sram_en"}, 32'(sram_en), 0);
        chk({tag, " sram_wen"}, 32'(sram_wen), 0);
        chk({tag, " sram_addr"}, sram_addr, 0);
        chk({tag, " sram_wdata"}, sram_wdata, 0);
        chk({tag, " inst_rvalid"}, 32'(inst_rvalid), 0);
        chk({tag, " data_rvalid"}, 32'(data_rvalid), 0);
        chk({tag, " inst_rdata"}, inst_rdata, 0);
        chk({tag, " data_rdata"}, data_rdata, 0);
    endtask

    initial begin
        // Each row: inputs this cycle, expected grant/port now, expected response to the previous row.
        vecs[0]  = mk(0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        32'h11111111,
                      0, 0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0);
        vecs[1]  = mk(1, 32'hBFC00000, 0, 4'h0, 32'h0,        32'h0,        32'h22222222,
                      1, 0, 4'h0, 32'hBFC00000, 32'h0,        0, 0, 32'h0,        32'h0);
        vecs[2]  = mk(0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        32'h24080001,
                      0, 0, 4'h0, 32'h0,        32'h0,        1, 0, 32'h24080001, 32'h0);
        vecs[3]  = mk(1, 32'hBFC00004, 1, 4'h0, 32'h80000010, 32'h13572468, 32'h00000055,
                      0, 1, 4'h0, 32'h80000010, 32'h13572468, 0, 0, 32'h0,        32'h0);
        vecs[4]  = mk(0, 32'h0,        1, 4'hF, 32'h80000020, 32'hDEADBEEF, 32'hCAFEF00D,
                      0, 1, 4'hF, 32'h80000020, 32'hDEADBEEF, 0, 1, 32'h0,        32'hCAFEF00D);
        vecs[5]  = mk(1, 32'hBFC00008, 0, 4'h0, 32'h0,        32'h0,        32'h12345678,
                      1, 0, 4'h0, 32'hBFC00008, 32'h0,        0, 1, 32'h0,        32'h0);
        vecs[6]  = mk(0, 32'h0,        1, 4'h0, 32'h80000030, 32'h0,        32'hA5A5A5A5,
                      0, 1, 4'h0, 32'h80000030, 32'h0,        1, 0, 32'hA5A5A5A5, 32'h0);
        vecs[7]  = mk(1, 32'hBFC0000C, 0, 4'h0, 32'h0,        32'h0,        32'h0BADF00D,
                      1, 0, 4'h0, 32'hBFC0000C, 32'h0,        0, 1, 32'h0,        32'h0BADF00D);
        vecs[8]  = mk(0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        32'h77777777,
                      0, 0, 4'h0, 32'h0,        32'h0,        1, 0, 32'h77777777, 32'h0);
        vecs[9]  = mk(0, 32'h0,        1, 4'h3, 32'h80000040, 32'h0000ABCD, 32'h99999999,
                      0, 1, 4'h3, 32'h80000040, 32'h0000ABCD, 0, 0, 32'h0,        32'h0);
        vecs[10] = mk(0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        32'h88888888,
                      0, 0, 4'h0, 32'h0,        32'h0,        0, 1, 32'h0,        32'h0);

        sram_rdata = 32'hFFFFFFFF;
        #2;
        chk_idle_port("reset");
        @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            inst_req = vecs[i].ireq; inst_addr = vecs[i].iaddr;
            data_req = vecs[i].dreq; data_wen = vecs[i].dwen;
            data_addr = vecs[i].daddr; data_wdata = vecs[i].dwdata;
            sram_rdata = vecs[i].srd;
            #1;
            chk($sformatf("v%0d inst_gnt", i), 32'(inst_gnt), 32'(vecs[i].eig));
            chk($sformatf("v%0d data_gnt", i), 32'(data_gnt), 32'(vecs[i].edg));
            chk($sformatf("v%0d sram_en", i), 32'(sram_en), 32'(vecs[i].eig | vecs[i].edg));
            chk($sformatf("v%0d sram_wen", i), 32'(sram_wen), 32'(vecs[i].ewen));
            chk($sformatf("v%0d sram_addr", i), sram_addr, vecs[i].eaddr);
            chk($sformatf("v%0d sram_wdata", i), sram_wdata, vecs[i].ewdata);
            chk($sformatf("v%0d inst_rvalid", i), 32'(inst_rvalid), 32'(vecs[i].eirv));
            chk($sformatf("v%0d data_rvalid", i), 32'(data_rvalid), 32'(vecs[i].edrv));
            chk($sformatf("v%0d inst_rdata", i), inst_rdata, vecs[i].eird);
            chk($sformatf("v%0d data_rdata", i), data_rdata, vecs[i].edrd);
        end

        // Both held high: four data grants, then the fetch gets through, repeating.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            inst_req = 1'b1; inst_addr = 32'h00000100;
            data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h00000200; data_wdata = '0;
            #1;
            chk($sformatf("starve%0d data_gnt", k), 32'(data_gnt), 32'(k % 5 != 4));
            chk($sformatf("starve%0d inst_gnt", k), 32'(inst_gnt), 32'(k % 5 == 4));
            chk($sformatf("starve%0d sram_addr", k), sram_addr,
                k % 5 == 4 ? 32'h00000100 : 32'h00000200);
        end

        // Withdrawing the fetch clears the starvation count, so data wins again afterwards.
        for (int k = 0; k < 4; k++) @(negedge clk);
        inst_req = 1'b0;
        #1;
        chk("withdraw data_gnt", 32'(data_gnt), 1);
        chk("withdraw inst_gnt", 32'(inst_gnt), 0);
        @(negedge clk);
        inst_req = 1'b1;
        #1;
        chk("after withdraw data_gnt", 32'(data_gnt), 1);
        chk("after withdraw inst_gnt", 32'(inst_gnt), 0);

        // Async reset in the response cycle of a data grant discards it.
        @(negedge clk);
        inst_req = 1'b0; data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h80000050;
        sram_rdata = 32'h5A5A5A5A;
        #1;
        chk("rst pre data_gnt", 32'(data_gnt), 1);
        @(posedge clk);
        #1;
        chk("rst pre data_rvalid", 32'(data_rvalid), 1);
        inst_req = 1'b1;
        resetn = 1'b0;
        #1;
        chk_idle_port("async rst");
        @(negedge clk);
        inst_req = 1'b0; data_req = 1'b0;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("post rst data_rvalid", 32'(data_rvalid), 0);
        chk("post rst inst_rvalid", 32'(inst_rvalid), 0);
        chk("post rst data_rdata", data_rdata, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
